// File: rtl/pueo_l2_pkg.sv
// Shared types and defaults for the PUEO level-two trigger: L2 mode encoding,
// geometry defaults and trig_src bit positions.
package pueo_l2_pkg;

  localparam int NPOL_DEF     = 2;
  localparam int NSECT_DEF    = 12;
  localparam int NREGION_DEF  = 4;
  localparam int WIN_BITS_DEF = 3;
  localparam int NMETA_DEF    = 4;

  // Mode 3 is treated like L2_MODE_OFF.
  typedef enum logic [1:0] {
    L2_MODE_OR        = 2'd0,
    L2_MODE_NEIGHBOUR = 2'd1,
    L2_MODE_OFF       = 2'd2
  } l2_mode_e;

  // Bit positions inside src_mask_i / trig_src_o for the default polarization count.
  localparam int SRC_L2_0 = 0;
  localparam int SRC_LF   = NPOL_DEF;
  localparam int SRC_AUX  = NPOL_DEF + 1;

endpackage

// File: rtl/pueo_l2_stretch.sv
// Array of retriggerable hit stretchers: each bit stays asserted for window
// extra ce cycles after its last hit. A new hit reloads the counter.
module pueo_l2_stretch
  import pueo_l2_pkg::*;
#(
  parameter int WIDTH    = 48,
  parameter int WIN_BITS = WIN_BITS_DEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                ce_i,
  input  logic [WIDTH-1:0]    hit,
  input  logic [WIN_BITS-1:0] window,
  output logic [WIDTH-1:0]    stretched,
  output logic                any_hit
);

  logic [WIDTH-1:0]    hit_q;
  logic [WIN_BITS-1:0] cnt [WIDTH];

  // The counter holds during the cycle hit_q is high, so it covers exactly
  // window cycles beyond the registered hit.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hit_q <= '0;
      // NOTE: the counter array is reset explicitly; a pending stretch must not
      // survive reset and produce a trigger from pre-reset hits.
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else if (ce_i) begin
      hit_q <= hit;
      for (int i = 0; i < WIDTH; i++) begin
        if (hit[i])
          cnt[i] <= window;
        else if (cnt[i] != '0 && !hit_q[i])
          cnt[i] <= cnt[i] - WIN_BITS'(1);
      end
    end
  end

  always_comb begin
    stretched = '0;
    for (int i = 0; i < WIDTH; i++) stretched[i] = hit_q[i] | (cnt[i] != '0);
  end

  assign any_hit = |hit_q;

endmodule

// File: rtl/pueo_leveltwo_coinc.sv
// PUEO L2 trigger: stretched neighbour coincidence (or V1 OR mode) per pol,
// merged with LF/aux, masked and held off to form trig_o; meta delayed to match.
module pueo_leveltwo_coinc
  import pueo_l2_pkg::*;
#(
  parameter int NPOL     = NPOL_DEF,
  parameter int NSECT    = NSECT_DEF,
  parameter int NREGION  = NREGION_DEF,
  parameter int WIN_BITS = WIN_BITS_DEF,
  parameter int NMETA    = NMETA_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        ce_i,
  input  logic [NPOL*NSECT*NREGION-1:0] hit_low_i,
  input  logic [NPOL*NSECT*NREGION-1:0] hit_high_i,
  input  logic [NPOL-1:0]             lf_i,
  input  logic                        aux_i,
  input  logic [1:0]                  mode_i,
  input  logic [WIN_BITS-1:0]         window_i,
  input  logic [NPOL+1:0]             src_mask_i,
  input  logic [15:0]                 holdoff_len_i,
  input  logic                        holdoff_i,
  input  logic                        dead_i,
  input  logic [NMETA*64-1:0]         meta_i,
  output logic [NMETA*64-1:0]         meta_o,
  output logic [NPOL-1:0]             leveltwo_o,
  output logic                        trig_o,
  output logic [NPOL+1:0]             trig_src_o,
  output logic                        busy_o
);

  localparam int NBIT = NSECT * NREGION;

  logic [NPOL-1:0][NBIT-1:0] s_low, s_high;
  logic [NPOL-1:0]           low_any, high_any_unused;

  for (genvar p = 0; p < NPOL; p++) begin : g_pol
    pueo_l2_stretch #(.WIDTH(NBIT), .WIN_BITS(WIN_BITS)) u_low (
      .clk_i, .rst_n_i, .ce_i,
      .hit       (hit_low_i[p*NBIT +: NBIT]),
      .window    (window_i),
      .stretched (s_low[p]),
      .any_hit   (low_any[p])
    );
    pueo_l2_stretch #(.WIDTH(NBIT), .WIN_BITS(WIN_BITS)) u_high (
      .clk_i, .rst_n_i, .ce_i,
      .hit       (hit_high_i[p*NBIT +: NBIT]),
      .window    (window_i),
      .stretched (s_high[p]),
      .any_hit   (high_any_unused[p])
    );
  end

  // Rotating high right by one sector lines high[s+1] up with low[s], ring wrap included.
  logic [NPOL-1:0] l2_next;
  always_comb begin
    l2_next = '0;
    for (int p = 0; p < NPOL; p++) begin
      case (mode_i)
        L2_MODE_NEIGHBOUR:
          l2_next[p] = |(s_low[p] & {s_high[p][NREGION-1:0], s_high[p][NBIT-1:NREGION]});
        L2_MODE_OR: l2_next[p] = low_any[p];
        default:    l2_next[p] = 1'b0;
      endcase
    end
  end

  logic [NPOL-1:0]     l2_q, lf_q1, lf_q2;
  logic                aux_q1, aux_q2;
  logic [NMETA*64-1:0] meta_q1, meta_q2;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      l2_q    <= '0;
      lf_q1   <= '0;
      lf_q2   <= '0;
      aux_q1  <= 1'b0;
      aux_q2  <= 1'b0;
      meta_q1 <= '0;
      meta_q2 <= '0;
    end else if (ce_i) begin
      l2_q    <= l2_next;
      lf_q1   <= lf_i;
      lf_q2   <= lf_q1;
      aux_q1  <= aux_i;
      aux_q2  <= aux_q1;
      meta_q1 <= meta_i;
      meta_q2 <= meta_q1;
    end
  end

  logic [15:0]     hold_cnt;
  logic [NPOL+1:0] cand;
  logic            fire;

  assign busy_o = (hold_cnt != '0);
  assign cand   = {aux_q2, |lf_q2, l2_q} & src_mask_i;
  assign fire   = ce_i & (|cand) & !holdoff_i & !dead_i & !busy_o;

  // NOTE: the master stage runs every clk so trig_o and leveltwo_o drop back
  // to 0 on the clk following the ce cycle, giving one-clk pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      trig_o     <= 1'b0;
      trig_src_o <= '0;
      leveltwo_o <= '0;
      hold_cnt   <= '0;
      meta_o     <= '0;
    end else begin
      trig_o     <= fire;
      trig_src_o <= fire ? cand : '0;
      leveltwo_o <= ce_i ? l2_q : '0;
      if (fire)
        hold_cnt <= holdoff_len_i;
      else if (ce_i && busy_o)
        hold_cnt <= hold_cnt - 16'd1;
      if (ce_i) meta_o <= meta_q2;
    end
  end

endmodule

// File: tb/tb_pueo_leveltwo_coinc.sv
// Directed and randomized bench for pueo_leveltwo_coinc against a per-ce
// behavioural model built on last-hit times and last-trigger times.
module tb_pueo_leveltwo_coinc;
  import pueo_l2_pkg::*;

  localparam int NPOL = 2, NSECT = 12, NREGION = 4, WIN_BITS = 3, NMETA = 4;
  localparam int NBIT = NSECT * NREGION, NHIT = NPOL * NBIT, NSRC = NPOL + 2;
  localparam int MW = NMETA * 64, MAXCE = 4096;

  logic              clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
  logic [NHIT-1:0]   hit_low = '0, hit_high = '0;
  logic [NPOL-1:0]   lf = '0;
  logic              aux = 1'b0;
  logic [1:0]        mode = 2'd1;
  logic [WIN_BITS-1:0] window = '0;
  logic [NSRC-1:0]   src_mask = '1;
  logic [15:0]       holdoff_len = '0;
  logic              holdoff = 1'b0, dead = 1'b0;
  logic [MW-1:0]     meta = '0;
  logic [MW-1:0]     meta_o;
  logic [NPOL-1:0]   leveltwo_o;
  logic              trig_o, busy_o;
  logic [NSRC-1:0]   trig_src_o;

  always #5 clk = ~clk;

  pueo_leveltwo_coinc #(.NPOL(NPOL), .NSECT(NSECT), .NREGION(NREGION),
                        .WIN_BITS(WIN_BITS), .NMETA(NMETA)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce),
    .hit_low_i(hit_low), .hit_high_i(hit_high), .lf_i(lf), .aux_i(aux),
    .mode_i(mode), .window_i(window), .src_mask_i(src_mask),
    .holdoff_len_i(holdoff_len), .holdoff_i(holdoff), .dead_i(dead),
    .meta_i(meta), .meta_o(meta_o), .leveltwo_o(leveltwo_o),
    .trig_o(trig_o), .trig_src_o(trig_src_o), .busy_o(busy_o)
  );

  int total = 0, bad = 0;

  // Model: per-ce snapshots of stretched state and delayed inputs.
  logic [NHIT-1:0] sn_sl [MAXCE], sn_sh [MAXCE], sn_hl [MAXCE];
  logic [NPOL-1:0] sn_lf [MAXCE];
  logic            sn_aux [MAXCE];
  logic [MW-1:0]   sn_meta [MAXCE];
  logic [1:0]      sn_mode [MAXCE];
  int lh_l [NHIT], lw_l [NHIT], lh_h [NHIT], lw_h [NHIT];
  int n = 0, base = 0, last_trig = -100000, last_hlen = 0;

  logic            cap_trig, cap_busy;
  logic [NSRC-1:0] cap_src;
  logic [NPOL-1:0] cap_lv;
  logic [MW-1:0]   cap_meta;

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s ce=%0d: observed %h expected %h", tag, n, got, exp);
    end
  endtask

  function automatic logic [NPOL-1:0] ref_l2(input int idx, input logic [1:0] md);
    logic [NPOL-1:0] r;
    r = '0;
    if (idx >= base) begin
      for (int p = 0; p < NPOL; p++) begin
        if (md == 2'd1) begin
          for (int s = 0; s < NSECT; s++)
            for (int g = 0; g < NREGION; g++)
              if (sn_sl[idx][p*NBIT + s*NREGION + g] &&
                  sn_sh[idx][p*NBIT + ((s+1) % NSECT)*NREGION + g]) r[p] = 1'b1;
        end else if (md == 2'd0) begin
          r[p] = |sn_hl[idx][p*NBIT +: NBIT];
        end
      end
    end
    return r;
  endfunction

  task automatic ce_step();
    logic [NPOL-1:0] l2e;
    logic lfe, auxe, fire, busy_e;
    logic [NSRC-1:0] cand;
    logic [MW-1:0] meta_e;
    @(negedge clk);
    ce = 1'b1;
    for (int b = 0; b < NHIT; b++) begin
      if (hit_low[b])  begin lh_l[b] = n; lw_l[b] = int'(window); end
      if (hit_high[b]) begin lh_h[b] = n; lw_h[b] = int'(window); end
      sn_sl[n][b] = (lh_l[b] >= base) && (n - lh_l[b] <= lw_l[b]);
      sn_sh[n][b] = (lh_h[b] >= base) && (n - lh_h[b] <= lw_h[b]);
    end
    sn_hl[n] = hit_low; sn_lf[n] = lf; sn_aux[n] = aux;
    sn_meta[n] = meta; sn_mode[n] = mode;
    l2e    = (n >= 1) ? ref_l2(n - 2, sn_mode[n-1]) : '0;
    lfe    = (n - 2 >= base) ? |sn_lf[n-2] : 1'b0;
    auxe   = (n - 2 >= base) ? sn_aux[n-2] : 1'b0;
    meta_e = (n - 2 >= base) ? sn_meta[n-2] : '0;
    cand   = {auxe, lfe, l2e} & src_mask;
    fire   = (|cand) && !holdoff && !dead && !(n - last_trig <= last_hlen);
    if (fire) begin last_trig = n; last_hlen = int'(holdoff_len); end
    busy_e = (n - last_trig) < last_hlen;
    @(posedge clk);
    @(negedge clk);
    cap_trig = trig_o; cap_src = trig_src_o; cap_lv = leveltwo_o;
    cap_busy = busy_o; cap_meta = meta_o;
    ce = 1'b0;
    check("trig", MW'(trig_o), MW'(fire));
    check("trig_src", MW'(trig_src_o), MW'(fire ? cand : '0));
    check("leveltwo", MW'(leveltwo_o), MW'(l2e));
    check("busy", MW'(busy_o), MW'(busy_e));
    check("meta", meta_o, meta_e);
    @(posedge clk);
    #1;
    check("trig_gap", MW'(trig_o), '0);
    check("leveltwo_gap", MW'(leveltwo_o), '0);
    n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ce = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1; ce = 1'b0;
    check("rst_trig", MW'(trig_o), '0);
    check("rst_src", MW'(trig_src_o), '0);
    check("rst_leveltwo", MW'(leveltwo_o), '0);
    check("rst_busy", MW'(busy_o), '0);
    check("rst_meta", meta_o, '0);
    base = n;
    for (int b = 0; b < NHIT; b++) begin lh_l[b] = -1; lh_h[b] = -1; end
    last_trig = -100000; last_hlen = 0;
  endtask

  task automatic idle();
    hit_low = '0; hit_high = '0; lf = '0; aux = 1'b0;
  endtask

  function automatic logic [NHIT-1:0] rnd_sparse();
    logic [NHIT-1:0] v;
    for (int i = 0; i < NHIT; i += 32)
      v[i +: 32] = $urandom & $urandom & $urandom & $urandom & $urandom;
    return v;
  endfunction

  function automatic logic [MW-1:0] rnd_meta();
    logic [MW-1:0] v;
    for (int i = 0; i < MW; i += 32) v[i +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [MW-1:0] tag_meta;
    logic [23:0] tmap, lmap, bmap;
    logic miss;
    tag_meta = {NMETA{64'hA5A5_A5A5_A5A5_A5A5}};
    for (int b = 0; b < NHIT; b++) begin lh_l[b] = -1; lh_h[b] = -1; lw_l[b] = 0; lw_h[b] = 0; end
    do_reset();

    // Neighbour pair pol0 s3r1 low / s4r1 high, plus meta alignment.
    mode = 2'd1; window = 3'd0; src_mask = '1; holdoff_len = 16'd0;
    meta = rnd_meta();
    repeat (3) ce_step();
    hit_low[0*NBIT + 3*NREGION + 1] = 1'b1;
    hit_high[0*NBIT + 4*NREGION + 1] = 1'b1;
    meta = tag_meta;
    ce_step();
    idle(); meta = rnd_meta();
    ce_step();
    ce_step();
    check("t1_trig", MW'(cap_trig), MW'(1'b1));
    check("t1_src", MW'(cap_src), MW'(4'b0001));
    check("t6_meta_align", cap_meta, tag_meta);

    // Ring wrap pol1: low s11r0 at k, high s0r0 at k+2 with window 2.
    window = 3'd2;
    repeat (4) ce_step();
    hit_low[1*NBIT + 11*NREGION] = 1'b1; ce_step();
    idle(); ce_step();
    hit_high[1*NBIT + 0] = 1'b1; ce_step();
    idle(); ce_step();
    ce_step();
    check("t2_wrap_trig", MW'(cap_trig), MW'(1'b1));
    check("t2_wrap_src", MW'(cap_src), MW'(4'b0010));
    repeat (4) ce_step();
    miss = 1'b0;
    hit_low[1*NBIT + 11*NREGION] = 1'b1; ce_step(); miss |= cap_trig;
    idle(); ce_step(); miss |= cap_trig;
    ce_step(); miss |= cap_trig;
    hit_high[1*NBIT + 0] = 1'b1; ce_step(); miss |= cap_trig;
    idle();
    repeat (4) begin ce_step(); miss |= cap_trig; end
    check("t2_late_none", MW'(miss), '0);

    // OR mode with self-holdoff of 5 ce, hit every ce for 20 ce.
    mode = 2'd0; src_mask = 4'b0011; holdoff_len = 16'd5; window = 3'd0;
    repeat (4) ce_step();
    for (int j = 0; j < 24; j++) begin
      hit_low[0] = (j < 20);
      ce_step();
      tmap[j] = cap_trig; lmap[j] = cap_lv[0]; bmap[j] = cap_busy;
    end
    check("t3_trig_map", MW'(tmap), MW'(24'h104104));
    check("t3_lv_map", MW'(lmap), MW'(24'h3FFFFC));
    check("t3_busy_map", MW'(bmap), MW'(24'hF7DF7C));
    idle();
    repeat (6) ce_step();

    // Aux masked off, then aux enabled but DAQ dead.
    mode = 2'd2; src_mask = 4'b0111; holdoff_len = 16'd3;
    miss = 1'b0;
    aux = 1'b1; ce_step(); aux = 1'b0;
    repeat (4) begin ce_step(); miss |= cap_trig; end
    check("t4_mask_none", MW'(miss), '0);
    src_mask = 4'hF; dead = 1'b1; miss = 1'b0;
    aux = 1'b1; ce_step(); aux = 1'b0;
    repeat (4) begin ce_step(); miss |= cap_trig | cap_busy; end
    check("t4_dead_none", MW'(miss), '0);
    dead = 1'b0;

    // Reset mid-window discards a pending stretch.
    mode = 2'd1; window = 3'd7; holdoff_len = 16'd0;
    hit_low[0*NBIT + 3*NREGION + 1] = 1'b1; ce_step();
    idle();
    do_reset();
    miss = 1'b0;
    ce_step(); miss |= cap_trig;
    hit_high[0*NBIT + 4*NREGION + 1] = 1'b1; ce_step(); miss |= cap_trig;
    idle();
    repeat (4) begin ce_step(); miss |= cap_trig; end
    check("t5_reset_none", MW'(miss), '0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) window = WIN_BITS'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) src_mask = NSRC'($urandom);
      holdoff_len = 16'($urandom_range(0, 6));
      holdoff = ($urandom_range(0, 7) == 0);
      dead    = ($urandom_range(0, 7) == 0);
      hit_low  = ($urandom_range(0, 1) == 0) ? rnd_sparse() : '0;
      hit_high = ($urandom_range(0, 1) == 0) ? rnd_sparse() : '0;
      lf  = ($urandom_range(0, 9) == 0) ? NPOL'($urandom_range(1, 3)) : '0;
      aux = ($urandom_range(0, 11) == 0);
      meta = rnd_meta();
      if ($urandom_range(0, 99) == 0) do_reset();
      ce_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
